rr_arbiter_4: RTL and testbench



---
 rtl/rr_arbiter_4.sv | 139 +++++++++++++
 tb/tb_rr_arbiter_4.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rr_arbiter_4.sv
// Four-requester round-robin arbiter with hold-until-release and a fairness timeout.
// The registered grant vector is always one-hot or all-zero, so the downstream priority
// encoder never sees more than one set bit. After any release the arbiter spends exactly
// one cycle idle before the next grant, and priority rotates past the last owner.
module rr_arbiter_4 #(
  parameter int unsigned TIMEOUT = 8
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [3:0] req_i,
  input  logic       done_i,
  output logic [3:0] grant_o,
  output logic       busy_o,
  output logic       timeout_o
);

  localparam int unsigned CntW = $clog2(TIMEOUT + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT);

  typedef enum logic [0:0] {StIdle, StGrant} state_e;

  state_e          state_q, state_d;
  logic [1:0]      ptr_q, ptr_d;
  logic [1:0]      owner_q, owner_d;
  logic [CntW-1:0] hold_cnt_q, hold_cnt_d;
  logic [3:0]      grant_q, grant_d;
  logic            busy_q, busy_d;
  logic            timeout_q, timeout_d;

  logic            pick_valid;
  logic [1:0]      pick_idx;
  logic [1:0]      cand;
  logic            hold_at_max;
  logic            owner_req;
  logic            rel_c;
  logic            force_rel;

  // Rotating-priority search: first requester at or after ptr_q, modulo 4.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = ptr_q;
    cand       = ptr_q;
    for (int i = 0; i < 4; i++) begin
      cand = ptr_q + 2'(i);
      if (!pick_valid && req_i[cand]) begin
        pick_valid = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  // Release conditions for the current owner; forced release only when the budget alone ends it.
  always_comb begin
    hold_at_max = (hold_cnt_q == CntMax);
    owner_req   = req_i[owner_q];
    rel_c       = done_i | ~owner_req | hold_at_max;
    force_rel   = hold_at_max & ~done_i & owner_req;
  end

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: grant from idle on any request, drop back to idle on release.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (pick_valid) state_d = StGrant;
      StGrant: if (rel_c)      state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Next values of the pointer, owner, hold counter and the registered outputs.
  always_comb begin
    ptr_d      = ptr_q;
    owner_d    = owner_q;
    hold_cnt_d = hold_cnt_q;
    grant_d    = grant_q;
    busy_d     = busy_q;
    timeout_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        grant_d = 4'b0000;
        busy_d  = 1'b0;
        if (pick_valid) begin
          grant_d    = 4'b0001 << pick_idx;
          owner_d    = pick_idx;
          hold_cnt_d = CntW'(1);
          busy_d     = 1'b1;
        end
      end
      StGrant: begin
        if (rel_c) begin
          grant_d    = 4'b0000;
          busy_d     = 1'b0;
          ptr_d      = owner_q + 2'd1;
          hold_cnt_d = '0;
          timeout_d  = force_rel;
        end else if (!hold_at_max) begin
          hold_cnt_d = hold_cnt_q + CntW'(1);
        end
      end
      default: begin
        grant_d = 4'b0000;
        busy_d  = 1'b0;
      end
    endcase
  end

  // Datapath and output registers; reset clears outputs without waiting for a clock edge.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q      <= 2'd0;
      owner_q    <= 2'd0;
      hold_cnt_q <= '0;
      grant_q    <= 4'b0000;
      busy_q     <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      ptr_q      <= ptr_d;
      owner_q    <= owner_d;
      hold_cnt_q <= hold_cnt_d;
      grant_q    <= grant_d;
      busy_q     <= busy_d;
      timeout_q  <= timeout_d;
    end
  end

  assign grant_o   = grant_q;
  assign busy_o    = busy_q;
  assign timeout_o = timeout_q;

endmodule

// File: tb/tb_rr_arbiter_4.sv
// Bench for rr_arbiter_4: each scenario drives one cycle at a time, pushes the expected
// {grant, busy, timeout} for the following edge, and drains/compares at the end of the task.
module tb_rr_arbiter_4;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic       done;
  logic [3:0] grant;
  logic       busy;
  logic       tmo;

  int n_tests = 0;
  int n_fail  = 0;

  logic [5:0] exp_q[$];
  logic [5:0] obs_q[$];

  rr_arbiter_4 #(.TIMEOUT(8)) dut (
    .clk_i    (clk),
    .rst_ni   (rst_n),
    .req_i    (req),
    .done_i   (done),
    .grant_o  (grant),
    .busy_o   (busy),
    .timeout_o(tmo)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, n_fail=%0d", n_fail);
    $fatal(1, "watchdog expired");
  end

  // One cycle: drive inputs, record the expectation, sample the DUT #1 after the edge.
  task automatic cyc(input logic [3:0] r, input logic d, input logic [3:0] eg, input logic et);
    req  = r;
    done = d;
    exp_q.push_back({eg, |eg, et});
    @(posedge clk);
    #1;
    obs_q.push_back({grant, busy, tmo});
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req   = 4'b0000;
    done  = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    logic [5:0] e, o;
    int k = 0;
    rst_n = 1'b0;
    req   = 4'b1111;
    done  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_tests++;
    if (grant !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_grant: got %b want 0000", grant);
    end
    n_tests++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_busy: got %b want 0", busy);
    end
    n_tests++;
    if (tmo !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_timeout: got %b want 0", tmo);
    end
    rst_n = 1'b1;
    cyc(4'b1111, 1'b0, 4'b0001, 1'b0);
    cyc(4'b0000, 1'b0, 4'b0000, 1'b0);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      n_tests++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL reset_seq[%0d]: got g=%b b=%b t=%b want g=%b b=%b t=%b",
                 k, o[5:2], o[1], o[0], e[5:2], e[1], e[0]);
      end
      k++;
    end
  endtask

  task automatic test_rotation();
    logic [5:0] e, o;
    int k = 0;
    do_reset();
    cyc(4'b1010, 1'b0, 4'b0010, 1'b0);
    cyc(4'b1010, 1'b1, 4'b0000, 1'b0);
    cyc(4'b1010, 1'b0, 4'b1000, 1'b0);
    cyc(4'b0000, 1'b0, 4'b0000, 1'b0);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      n_tests++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL rotation[%0d]: got g=%b b=%b t=%b want g=%b b=%b t=%b",
                 k, o[5:2], o[1], o[0], e[5:2], e[1], e[0]);
      end
      k++;
    end
  endtask

  task automatic test_fairness();
    logic [5:0] e, o;
    logic [3:0] seq [9];
    int k = 0;
    seq = '{4'b0001, 4'b0000, 4'b0010, 4'b0000, 4'b0100, 4'b0000, 4'b1000, 4'b0000, 4'b0001};
    do_reset();
    // done is raised in the first cycle of each grant, i.e. while the previous sample showed one.
    for (int i = 0; i < 9; i++) begin
      cyc(4'b1111, (i % 2) == 1, seq[i], 1'b0);
    end
    cyc(4'b0000, 1'b0, 4'b0000, 1'b0);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      n_tests++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL fairness[%0d]: got g=%b b=%b t=%b want g=%b b=%b t=%b",
                 k, o[5:2], o[1], o[0], e[5:2], e[1], e[0]);
      end
      k++;
    end
  endtask

  task automatic test_timeout();
    logic [5:0] e, o;
    int k = 0;
    do_reset();
    // Forced release after exactly 8 grant cycles, one idle cycle with timeout, then regrant.
    for (int i = 0; i < 8; i++) cyc(4'b0100, 1'b0, 4'b0100, 1'b0);
    cyc(4'b0100, 1'b0, 4'b0000, 1'b1);
    cyc(4'b0100, 1'b0, 4'b0100, 1'b0);
    // done in the 8th grant cycle: normal release.
    for (int i = 0; i < 7; i++) cyc(4'b0100, 1'b0, 4'b0100, 1'b0);
    cyc(4'b0100, 1'b1, 4'b0000, 1'b0);
    // req drop in the 8th grant cycle: also no timeout.
    for (int i = 0; i < 8; i++) cyc(4'b0100, 1'b0, 4'b0100, 1'b0);
    cyc(4'b0000, 1'b0, 4'b0000, 1'b0);
    cyc(4'b0000, 1'b0, 4'b0000, 1'b0);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      n_tests++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL timeout[%0d]: got g=%b b=%b t=%b want g=%b b=%b t=%b",
                 k, o[5:2], o[1], o[0], e[5:2], e[1], e[0]);
      end
      k++;
    end
  endtask

  task automatic test_withdraw();
    logic [5:0] e, o;
    int k = 0;
    do_reset();
    cyc(4'b0001, 1'b0, 4'b0001, 1'b0);
    cyc(4'b1110, 1'b0, 4'b0000, 1'b0);
    cyc(4'b1110, 1'b0, 4'b0010, 1'b0);
    // Non-owner bits toggle while owner 1 keeps requesting.
    cyc(4'b1011, 1'b0, 4'b0010, 1'b0);
    cyc(4'b0110, 1'b0, 4'b0010, 1'b0);
    cyc(4'b1111, 1'b0, 4'b0010, 1'b0);
    cyc(4'b1101, 1'b0, 4'b0000, 1'b0);
    cyc(4'b1101, 1'b0, 4'b0100, 1'b0);
    cyc(4'b0000, 1'b0, 4'b0000, 1'b0);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      n_tests++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL withdraw[%0d]: got g=%b b=%b t=%b want g=%b b=%b t=%b",
                 k, o[5:2], o[1], o[0], e[5:2], e[1], e[0]);
      end
      k++;
    end
  endtask

  task automatic test_async_reset();
    logic [5:0] e, o;
    int k = 0;
    do_reset();
    cyc(4'b0100, 1'b0, 4'b0100, 1'b0);
    cyc(4'b0100, 1'b0, 4'b0100, 1'b0);
    // Drop reset between edges; outputs must clear before the next rising edge.
    #2;
    rst_n = 1'b0;
    #1;
    n_tests++;
    if ({grant, busy, tmo} !== 6'b000000) begin
      n_fail++;
      $display("FAIL async_reset: got g=%b b=%b t=%b want g=0000 b=0 t=0", grant, busy, tmo);
    end
    req = 4'b1111;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc(4'b1111, 1'b0, 4'b0001, 1'b0);
    cyc(4'b0000, 1'b0, 4'b0000, 1'b0);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      n_tests++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL async_seq[%0d]: got g=%b b=%b t=%b want g=%b b=%b t=%b",
                 k, o[5:2], o[1], o[0], e[5:2], e[1], e[0]);
      end
      k++;
    end
  endtask

  initial begin
    rst_n = 1'b0;
    req   = 4'b0000;
    done  = 1'b0;
    test_reset();
    test_rotation();
    test_fairness();
    test_timeout();
    test_withdraw();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
